// File: rtl/opb_register_bank_ppc2simulink.sv
// Double-buffered bank of NUM_REGS OPB-writable registers, committed atomically on user_sync.
// Define OPB_REGBANK_ACTIVE_READBACK_EN to read back active (instead of shadow) values.
module opb_register_bank_ppc2simulink #(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter int                      C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01000800,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010008FF,
  parameter int                      NUM_REGS     = 8,
  parameter logic [31:0]             RESET_VAL    = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic                      user_sync,
  output logic [NUM_REGS*32-1:0]    user_data_out,
  output logic                      user_commit
);

`ifdef OPB_REGBANK_ACTIVE_READBACK_EN
  localparam logic ACTIVE_RB = 1'b1;
`else
  localparam logic ACTIVE_RB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t      state;
  logic [31:0] word_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  be_p0;
  logic        rnw_p0;
  logic        ack_q;
  logic [31:0] dbus_q;
  logic [31:0] shadow_q [NUM_REGS];
  logic [31:0] active_q [NUM_REGS];
  logic        pending_q;
  logic        force_q;
  logic        commit_q;
  logic [15:0] commit_count;
  logic        hit;
  logic        wr_en;
  logic        commit;
  logic [31:0] ctrl_word;
  logic [31:0] rd_word;
  logic        unused_seq;

  // be[3] guards reg bits 31:24, i.e. OPB_BE[0] / DBus[0:7]
  function automatic logic [31:0] apply_be(input logic [31:0] cur, input logic [31:0] data,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  assign unused_seq = OPB_seqAddr;
  assign hit        = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign wr_en      = (state == ACK) && !rnw_p0;
  assign commit     = force_q || (pending_q && user_sync);
  assign ctrl_word  = {commit_count, 7'b0, ACTIVE_RB, 7'b0, pending_q};

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word_p0 == 32'(i)) rd_word = ACTIVE_RB ? active_q[i] : shadow_q[i];
    end
    if (word_p0 == 32'(NUM_REGS)) rd_word = ctrl_word;
  end

  // Stage p0: capture the decoded transfer when leaving IDLE
  always_ff @(posedge OPB_Clk) begin
    if (state == IDLE && hit) begin
      word_p0  <= 32'((OPB_ABus - C_BASEADDR) >> 2);
      wdata_p0 <= OPB_DBus;
      be_p0    <= OPB_BE;
      rnw_p0   <= OPB_RNW;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
      case (state)
        IDLE: if (hit) state <= ACK;
        ACK: begin
          ack_q <= 1'b1;
          if (rnw_p0) dbus_q <= rd_word;
          state <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit is evaluated before the bus write so a same-cycle write lands only in shadow
  // and a same-cycle ARM survives the commit.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VAL;
        active_q[i] <= RESET_VAL;
      end
      pending_q    <= 1'b0;
      force_q      <= 1'b0;
      commit_q     <= 1'b0;
      commit_count <= '0;
    end else begin
      commit_q <= 1'b0;
      if (commit) begin
        active_q     <= shadow_q;
        pending_q    <= 1'b0;
        force_q      <= 1'b0;
        commit_q     <= 1'b1;
        commit_count <= commit_count + 16'd1;
      end
      if (wr_en) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (word_p0 == 32'(i)) shadow_q[i] <= apply_be(shadow_q[i], wdata_p0, be_p0);
        end
        if (word_p0 == 32'(NUM_REGS) && be_p0[0]) begin
          if (wdata_p0[2])      pending_q <= 1'b0;
          else if (wdata_p0[0]) pending_q <= 1'b1;
          if (wdata_p0[1])      force_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      user_data_out[32*i +: 32] = active_q[i];
    end
  end

  assign Sl_DBus     = dbus_q;
  assign Sl_xferAck  = ack_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_commit = commit_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink (default build: shadow readback).
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01000800;
  localparam int NREG = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:31]       abus;
  logic [0:3]        be;
  logic [0:31]       dbus;
  logic              rnw;
  logic              sel;
  logic              seq_addr;
  logic [0:31]       sl_dbus;
  logic              sl_ack, sl_err, sl_retry, sl_tout;
  logic              user_sync;
  logic [NREG*32-1:0] user_data_out;
  logic              user_commit;

  int n_checks = 0;
  int n_fail = 0;
  int commit_pulses = 0;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr), .Sl_DBus(sl_dbus),
    .Sl_xferAck(sl_ack), .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .user_sync(user_sync), .user_data_out(user_data_out), .user_commit(user_commit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (user_commit) commit_pulses++;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(4 * w);
  endfunction

  function automatic logic [31:0] ureg(input int i);
    return user_data_out[32*i +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus = '0;
  endtask

  // One OPB transfer; lat = posedges from select to ack (0 = no ack within budget)
  task automatic xfer(input logic r, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    logic [31:0] tmp;
    @(negedge clk);
    sel = 1'b1; rnw = r; abus = a; be = b; dbus = d;
    lat = 0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (sl_ack) begin
        lat = c;
        tmp = sl_dbus;
        rd = tmp;
        break;
      end
    end
    bus_idle();
    @(negedge clk);
    check("ack_width", 32'(sl_ack), 32'd0);
    tmp = sl_dbus;
    check("dbus_idle_zero", tmp, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    xfer(1'b1, a, 4'hF, 32'h0, rd, lat);
    check({name, "_lat"}, 32'(lat), 32'd2);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    xfer(1'b0, a, 4'hF, d, rd, lat);
    check("wr_lat", 32'(lat), 32'd2);
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    user_sync = 1'b1;
    @(negedge clk);
    user_sync = 1'b0;
  endtask

  // Write whose applying edge coincides with a user_sync pulse
  task automatic xfer_with_sync(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = a; be = 4'hF; dbus = d;
    @(negedge clk);
    user_sync = 1'b1;
    @(negedge clk);
    user_sync = 1'b0;
    check("sync_wr_ack", 32'(sl_ack), 32'd1);
    check("sync_wr_commit", 32'(user_commit), 32'd1);
    bus_idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 required");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int p0;
    logic [31:0] tmp;

    for (int w = 0; w <= NREG; w++) vecs.push_back('{1'b1, wa(w), 4'hF, 32'h0, 32'h0});
    vecs.push_back('{1'b0, wa(3), 4'b1010, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b1, wa(3), 4'hF, 32'h0, 32'hDE00BE00});
    vecs.push_back('{1'b0, wa(0), 4'hF, 32'h12345678, 32'h0});
    vecs.push_back('{1'b1, wa(0), 4'hF, 32'h0, 32'h12345678});
    vecs.push_back('{1'b0, wa(1), 4'b0001, 32'hAABBCCDD, 32'h0});
    vecs.push_back('{1'b1, wa(1), 4'hF, 32'h0, 32'h000000DD});
    vecs.push_back('{1'b0, wa(7), 4'b0110, 32'hCAFEBABE, 32'h0});
    vecs.push_back('{1'b1, wa(7), 4'hF, 32'h0, 32'h00FEBA00});
    vecs.push_back('{1'b1, wa(NREG+1), 4'hF, 32'h0, 32'h0});
    vecs.push_back('{1'b0, wa(NREG+1), 4'hF, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{1'b1, wa(NREG+1), 4'hF, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h010008FC, 4'hF, 32'h0, 32'h0});

    rst = 1'b1; user_sync = 1'b0; seq_addr = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(sl_ack), 32'd0);
    tmp = sl_dbus;
    check("rst_dbus", tmp, 32'd0);
    check("rst_commit", 32'(user_commit), 32'd0);
    check("rst_err", {sl_err, sl_retry, sl_tout}, 32'd0);
    for (int i = 0; i < NREG; i++) check($sformatf("rst_user%0d", i), ureg(i), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].rnw, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      if (vecs[i].rnw) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end
    for (int i = 0; i < NREG; i++) check($sformatf("shadow_only_user%0d", i), ureg(i), 32'h0);

    xfer(1'b1, 32'h01000900, 4'hF, 32'h0, rd, lat);
    check("above_range_noack", 32'(lat), 32'd0);
    xfer(1'b1, 32'h010007FC, 4'hF, 32'h0, rd, lat);
    check("below_range_noack", 32'(lat), 32'd0);

    // ARM, then a late user_sync commits the whole bank
    wr(wa(NREG), 32'h1);
    rd_chk("ctrl_armed", wa(NREG), 32'h00000001);
    repeat (10) @(negedge clk);
    p0 = commit_pulses;
    pulse_sync();
    check("commit_user3", ureg(3), 32'hDE00BE00);
    check("commit_user0", ureg(0), 32'h12345678);
    check("commit_user7", ureg(7), 32'h00FEBA00);
    check("commit_pulse", 32'(user_commit), 32'd1);
    @(negedge clk);
    check("commit_pulse_end", 32'(user_commit), 32'd0);
    repeat (3) @(negedge clk);
    check("commit_pulse_count", 32'(commit_pulses - p0), 32'd1);
    rd_chk("ctrl_count1", wa(NREG), 32'h00010000);

    // ARM+ABORT leaves nothing pending
    wr(wa(1), 32'h11111111);
    wr(wa(NREG), 32'h5);
    rd_chk("ctrl_abort", wa(NREG), 32'h00010000);
    p0 = commit_pulses;
    pulse_sync();
    repeat (3) @(negedge clk);
    check("abort_no_commit", 32'(commit_pulses - p0), 32'd0);
    check("abort_user1", ureg(1), 32'h000000DD);
    rd_chk("ctrl_abort2", wa(NREG), 32'h00010000);

    // Shadow write coincident with commit: active keeps the pre-write value
    wr(wa(3), 32'h22222222);
    wr(wa(NREG), 32'h1);
    xfer_with_sync(wa(3), 32'h33333333);
    check("coinc_user3", ureg(3), 32'h22222222);
    rd_chk("coinc_shadow3", wa(3), 32'h33333333);
    rd_chk("ctrl_count2", wa(NREG), 32'h00020000);
    wr(wa(NREG), 32'h1);
    pulse_sync();
    check("second_user3", ureg(3), 32'h33333333);
    rd_chk("ctrl_count3", wa(NREG), 32'h00030000);

    // ARM coincident with commit stays pending
    wr(wa(2), 32'h44444444);
    wr(wa(NREG), 32'h1);
    xfer_with_sync(wa(NREG), 32'h1);
    check("rearm_user2", ureg(2), 32'h44444444);
    rd_chk("ctrl_rearm", wa(NREG), 32'h00040001);
    pulse_sync();
    rd_chk("ctrl_count5", wa(NREG), 32'h00050000);

    // FORCE commits without user_sync
    wr(wa(4), 32'h55555555);
    p0 = commit_pulses;
    wr(wa(NREG), 32'h2);
    repeat (3) @(negedge clk);
    check("force_pulse", 32'(commit_pulses - p0), 32'd1);
    check("force_user4", ureg(4), 32'h55555555);
    rd_chk("ctrl_force", wa(NREG), 32'h00060000);

    // Reset during the ACK cycle: no ack, everything back to RESET_VAL
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = wa(0); be = 4'hF; dbus = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_mid_pre_ack", 32'(sl_ack), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", 32'(sl_ack), 32'd0);
    tmp = sl_dbus;
    check("rst_mid_dbus", tmp, 32'd0);
    check("rst_mid_commit", 32'(user_commit), 32'd0);
    rst = 1'b0;
    bus_idle();
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_late_ack", 32'(sl_ack), 32'd0);
    end
    for (int i = 0; i < NREG; i++) check($sformatf("rst_mid_user%0d", i), ureg(i), 32'h0);
    rd_chk("rst_mid_w0", wa(0), 32'h0);
    rd_chk("rst_mid_w3", wa(3), 32'h0);
    rd_chk("rst_mid_ctrl", wa(NREG), 32'h0);
    rd_chk("rst_mid_spare", wa(NREG+1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Successor to the single-register PPC-to-Simulink OPB slave: a bank of NUM_REGS software-writable 32-bit registers with double buffering.
- Software writes shadow registers over OPB, then arms a commit. The whole bank transfers atomically to the user outputs on the next user frame strobe.
- Used for FIR coefficient sets and channel tables that must never be seen half-updated by the datapath.
- Single clock domain: user logic runs on OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01000800, first byte address of the bank.
- C_HIGHADDR, 32'h010008FF, last decoded byte address.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width (fixed at 32).
- NUM_REGS, 8, number of data registers (1..31).
- RESET_VAL, 32'h00000000, reset value of every shadow and active register.

Ports:
- OPB_Clk  in  1  sole clock
- OPB_Rst  in  1  synchronous active-high reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7] (MSB byte)
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1=read, 0=write
- OPB_select  in  1  transfer valid
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero when not acking
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- user_sync  in  1  frame-boundary strobe from datapath
- user_data_out  out  NUM_REGS*32  active registers; reg i at bits [32*i+31:32*i]
- user_commit  out  1  one-cycle pulse when active bank updates

Behaviour:
- Decode: hit = OPB_select and C_BASEADDR <= ABus <= C_HIGHADDR. Word index w = (ABus - C_BASEADDR) >> 2.
  - w < NUM_REGS: shadow register w.
  - w == NUM_REGS: CTRL.
  - Other in-range w: reads return 0, writes are discarded, still acked.
- Bus FSM states: IDLE, ACK, HOLD.
  - IDLE -> ACK on hit (registered address, data, RNW and BE).
  - ACK: Sl_xferAck=1 for exactly one cycle. Write applied this cycle. Sl_DBus carries read data this cycle only, and is 0 otherwise. Then -> HOLD.
  - HOLD: one cycle that ignores select, so the master can drop it. Then -> IDLE.
  - Read or write latency: ack 2 cycles after select rises.
- Writes honour byte enables per byte. Bit mapping: DBus[0] = reg bit 31.
- CTRL write bits (reg bit numbering):
  - bit0 ARM: sets pending.
  - bit1 FORCE: commits on the next cycle regardless of user_sync.
  - bit2 ABORT: clears pending. ABORT wins over ARM in the same write. FORCE with ABORT: FORCE still commits.
- CTRL read: bit0 = pending; bits[31:16] = commit_count; other bits 0.
- Commit occurs in the cycle where (pending and user_sync) or a registered force is set.
  - Active <= shadow for all registers.
  - pending <= 0.
  - commit_count += 1, wrapping 16'hFFFF -> 0.
  - user_commit = 1 in the following cycle.
- user_sync while not pending: no effect.
- Shadow write in the same cycle as a commit: active takes the pre-write shadow value; the new value stays in shadow.
- ARM write in the same cycle as a commit: pending ends set (the new arm survives).
- Reset (any cycle, including mid-transfer):
  - shadow = active = RESET_VAL; pending = 0; commit_count = 0.
  - FSM -> IDLE; Sl_xferAck = 0; Sl_DBus = 0; user_commit = 0.
  - An interrupted transfer is not acked.

Optional Feature:
- Macro: OPB_REGBANK_ACTIVE_READBACK_EN.
- Defined: reads of data words return the active value, and CTRL bit8 = 1 flags the active readback mode.
- Undefined: reads return the shadow value, and CTRL bit8 = 0.
- Writes always target shadow in both modes.

Test Plan:
- Reset then read word 0..NUM_REGS -> all RESET_VAL, CTRL=0; user_data_out=RESET_VAL; ack 2 cycles after select, exactly 1 cycle wide.
- Write 32'hDEADBEEF to word 3 with BE=4'b1010, read back -> 32'hDE00BE00 (shadow mode); user_data_out unchanged.
- Write CTRL=1, then pulse user_sync 10 cycles later -> user_data_out reg3 = 32'hDE00BE00 on the next edge; user_commit pulses once; CTRL reads 32'h00010000.
- Write CTRL=5 (ARM+ABORT), then pulse user_sync -> no commit; pending=0; count unchanged.
- Shadow write coincident with user_sync while pending -> active holds old value; a second ARM+sync then delivers the new value.
- Assert OPB_Rst during the ACK cycle -> no ack; all registers = RESET_VAL; next transfer completes normally. Addresses at word NUM_REGS+1 read 0 and are acked.
